// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types and constants for alu_sequencer.
//   op_e     : operation codes accepted on in_op (10..15 are illegal).
//   state_e  : sequencer FSM states.
//   ALU_*    : selector codes driven on alu_sel toward the external ALU.
//   SIGN_BIAS: flips the sign bit so an unsigned compare orders signed values.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_NOP  = 5'd31;

    localparam logic [31:0] SIGN_BIAS = 32'h8000_0000;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Sequences one operation at a time through an external combinational ALU.
//   Non-shift ops take a single EXEC cycle; shifts iterate a one-bit ALU
//   shift shamt times, feeding the accumulator back as operand 1.
//
// Ports
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : request handshake (ready only in IDLE)
//   in_op, in_a, in_b      : operation and operands (in_b[4:0] = shift amount)
//   alu_sel, alu_data1/2   : drive to the external ALU
//   alu_result             : combinational ALU result
//   out_valid/out_ready    : result handshake
//   out_result             : result, zero when out_valid is low
//   busy                   : any state other than IDLE
//   flush                  : only with ALU_SEQ_FLUSH_EN; aborts the operation
//
// Configuration macro: ALU_SEQ_FLUSH_EN
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
`ifdef ALU_SEQ_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [4:0]  alu_sel,
    output logic [31:0] alu_data1,
    output logic [31:0] alu_data2,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] acc_q;
    logic [4:0]  cnt_q;

    logic        flush_i;
    logic        accept;
    logic        exec_illegal;
    logic [4:0]  sel_c;
    logic [31:0] data1_c, data2_c;

`ifdef ALU_SEQ_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Flush wins over acceptance, so ready is withdrawn while it is asserted.
    assign in_ready   = rst_n && (state_q == ST_IDLE) && !flush_i;
    assign accept     = in_valid && in_ready;
    assign busy       = rst_n && (state_q != ST_IDLE);
    assign out_valid  = rst_n && (state_q == ST_DONE);
    assign out_result = out_valid ? acc_q : 32'd0;

    assign alu_sel    = rst_n ? sel_c   : 5'd0;
    assign alu_data1  = rst_n ? data1_c : 32'd0;
    assign alu_data2  = rst_n ? data2_c : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= in_op;
                a_q   <= in_a;
                b_q   <= in_b;
                // Shifts start from A; the accumulator is then shifted in place.
                acc_q <= in_a;
                cnt_q <= in_b[4:0];
            end else if (state_q == ST_EXEC) begin
                acc_q <= exec_illegal ? 32'd0 : alu_result;
            end else if (state_q == ST_SHIFT) begin
                acc_q <= alu_result;
                cnt_q <= cnt_q - 5'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_c        = ALU_ADD;
        data1_c      = 32'd0;
        data2_c      = 32'd0;
        exec_illegal = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift_op(in_op) && (in_b[4:0] != 5'd0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                state_d = ST_DONE;
                data1_c = a_q;
                data2_c = b_q;
                case (op_q)
                    OP_ADD:  sel_c = ALU_ADD;
                    OP_SUB:  sel_c = ALU_SUB;
                    OP_AND:  sel_c = ALU_AND;
                    OP_OR:   sel_c = ALU_OR;
                    OP_XOR:  sel_c = ALU_XOR;
                    OP_SLTU: sel_c = ALU_SLTU;
                    OP_SLT: begin
                        // Biasing both operands maps signed order onto unsigned order.
                        sel_c   = ALU_SLTU;
                        data1_c = a_q ^ SIGN_BIAS;
                        data2_c = b_q ^ SIGN_BIAS;
                    end
                    OP_SLL, OP_SRL, OP_SRA: begin
                        // Zero shift amount degenerates to a pass-through of A.
                        sel_c   = ALU_ADD;
                        data2_c = 32'd0;
                    end
                    default: begin
                        sel_c        = ALU_NOP;
                        data1_c      = 32'd0;
                        data2_c      = 32'd0;
                        exec_illegal = 1'b1;
                    end
                endcase
            end

            ST_SHIFT: begin
                data1_c = acc_q;
                data2_c = 32'd0;
                case (op_q)
                    OP_SLL:  sel_c = ALU_SLL;
                    OP_SRL:  sel_c = ALU_SRL;
                    default: sel_c = ALU_SRA;
                endcase
                // The final iteration is the one entered with a count of 1.
                if (cnt_q <= 5'd1) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a behavioural one-bit-shift ALU
//   attached to the alu_* ports. Flush scenarios build only with
//   ALU_SEQ_FLUSH_EN.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  alu_sel;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;
`ifdef ALU_SEQ_FLUSH_EN
    logic        flush;
`endif

    int n_pass;
    int n_total;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ALU_SEQ_FLUSH_EN
        .flush      (flush),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_sel    (alu_sel),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: shift selectors move data1 by one bit per cycle.
    always_comb begin
        alu_result = 32'd0;
        case (alu_sel)
            5'd0: alu_result = alu_data1 + alu_data2;
            5'd1: alu_result = alu_data1 - alu_data2;
            5'd2: alu_result = alu_data1 & alu_data2;
            5'd3: alu_result = alu_data1 | alu_data2;
            5'd4: alu_result = alu_data1 ^ alu_data2;
            5'd5: alu_result = alu_data1 << 1;
            5'd6: alu_result = alu_data1 >> 1;
            5'd7: alu_result = {alu_data1[31], alu_data1[31:1]};
            5'd9: alu_result = {31'd0, (alu_data1 < alu_data2)};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 4'hF;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'h0000_0003;
    endtask

    // Returns the cycle index (accept cycle = 0) at which out_valid is seen.
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({in_ready, busy, out_valid} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {in_ready, busy, out_valid});
        else n_pass++;
        n_total++;
        if ({out_result, alu_sel, alu_data1, alu_data2} !== 101'd0) $display("FAIL reset_data got %h want 0", {out_result, alu_sel, alu_data1, alu_data2});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        int c;
        issue(OP_ADD, 32'h7FFF_FFFF, 32'd1);
        n_total++;
        if (alu_sel !== 5'd0 || alu_data1 !== 32'h7FFF_FFFF || alu_data2 !== 32'd1)
            $display("FAIL add_exec_drive got sel=%0d d1=%h d2=%h want 0 7fffffff 1", alu_sel, alu_data1, alu_data2);
        else n_pass++;
        n_total++;
        if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL add_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
        else n_pass++;
        wait_valid(c);
        n_total++;
        if (c !== 2) $display("FAIL add_latency got %0d want 2", c);
        else n_pass++;
        n_total++;
        if (out_result !== 32'h8000_0000) $display("FAIL add_result got %h want 80000000", out_result);
        else n_pass++;
        n_total++;
        if (alu_sel !== 5'd0 || alu_data1 !== 32'd0) $display("FAIL done_alu_zero got sel=%0d d1=%h want 0 0", alu_sel, alu_data1);
        else n_pass++;
        finish_op();
        n_total++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || in_ready !== 1'b1)
            $display("FAIL add_after_hs got v=%b r=%h rdy=%b want 0 0 1", out_valid, out_result, in_ready);
        else n_pass++;
    endtask

    task automatic test_shift();
        int c;
        int n7;
        issue(OP_SRA, 32'h8000_0000, 32'd31);
        n7 = 0;
        c  = 1;
        while (out_valid !== 1'b1 && c < 64) begin
            if (alu_sel === 5'd7) n7++;
            @(posedge clk);
            #1;
            c++;
        end
        n_total++;
        if (n7 !== 31) $display("FAIL sra_sel_cycles got %0d want 31", n7);
        else n_pass++;
        n_total++;
        if (c !== 32) $display("FAIL sra_latency got %0d want 32", c);
        else n_pass++;
        n_total++;
        if (out_result !== 32'hFFFF_FFFF) $display("FAIL sra_result got %h want ffffffff", out_result);
        else n_pass++;
        finish_op();

        issue(OP_SLL, 32'h0000_1234, 32'h0000_0025);
        n_total++;
        if (alu_sel !== 5'd5 || alu_data1 !== 32'h0000_1234 || alu_data2 !== 32'd0)
            $display("FAIL sll_drive got sel=%0d d1=%h d2=%h want 5 1234 0", alu_sel, alu_data1, alu_data2);
        else n_pass++;
        wait_valid(c);
        n_total++;
        if (c !== 6) $display("FAIL sll_latency got %0d want 6", c);
        else n_pass++;
        n_total++;
        if (out_result !== 32'h0002_4680) $display("FAIL sll_result got %h want 00024680", out_result);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_compare();
        logic [3:0]  ops  [6] = '{OP_SLT, OP_SLTU, OP_SLL, 4'd12, OP_SUB, OP_XOR};
        logic [31:0] as   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234, 32'h5555_5555, 32'd5, 32'hF0F0_F0F0};
        logic [31:0] bs   [6] = '{32'd1, 32'd1, 32'd0, 32'h3333_3333, 32'd7, 32'hFF00_FF00};
        logic [31:0] exp  [6] = '{32'd1, 32'd0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFE, 32'h0FF0_0FF0};
        logic [4:0]  esel [6] = '{5'd9, 5'd9, 5'd0, 5'd31, 5'd1, 5'd4};
        int c;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i]);
            n_total++;
            if (alu_sel !== esel[i]) $display("FAIL cmp_sel[%0d] got %0d want %0d", i, alu_sel, esel[i]);
            else n_pass++;
            wait_valid(c);
            n_total++;
            if (c !== 2 || out_result !== exp[i])
                $display("FAIL cmp_result[%0d] got lat=%0d res=%h want lat=2 res=%h", i, c, out_result, exp[i]);
            else n_pass++;
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int c;
        issue(OP_ADD, 32'd5, 32'd7);
        wait_valid(c);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_ADD;
        in_a     = 32'd1;
        in_b     = 32'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_total++;
            if (out_valid !== 1'b1 || out_result !== 32'd12 || in_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] got v=%b r=%h rdy=%b want 1 0000000c 0", i, out_valid, out_result, in_ready);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_no_overlap got rdy=%b want 0", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_idle got v=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL bp_accept got busy=%b want 1", busy);
        else n_pass++;
        wait_valid(c);
        n_total++;
        if (c !== 2 || out_result !== 32'd3) $display("FAIL bp_next got lat=%0d res=%h want 2 3", c, out_result);
        else n_pass++;
        finish_op();
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        int c;
        issue(OP_SRA, 32'h8000_0000, 32'd31);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_total++;
        if ({in_ready, busy, out_valid, alu_sel} !== 8'd0) $display("FAIL midrst_in_reset got %b want 0", {in_ready, busy, out_valid, alu_sel});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL midrst_idle got rdy=%b busy=%b v=%b want 1 0 0", in_ready, busy, out_valid);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL midrst_stale got %0d valid cycles want 0", seen);
        else n_pass++;
        issue(OP_ADD, 32'd3, 32'd4);
        wait_valid(c);
        n_total++;
        if (c !== 2 || out_result !== 32'd7) $display("FAIL midrst_recover got lat=%0d res=%h want 2 7", c, out_result);
        else n_pass++;
        finish_op();
    endtask

`ifdef ALU_SEQ_FLUSH_EN
    task automatic test_flush();
        int c;
        issue(OP_SRA, 32'h8000_0000, 32'd31);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_shift got v=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
        else n_pass++;
        issue(OP_ADD, 32'd1, 32'd1);
        wait_valid(c);
        @(negedge clk);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_op     = OP_ADD;
        in_a      = 32'd9;
        in_b      = 32'd9;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL flush_done got v=%b busy=%b want 0 0", out_valid, busy);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
`ifdef ALU_SEQ_FLUSH_EN
        flush     = 1'b0;
`endif
        test_reset();
        test_add();
        test_shift();
        test_compare();
        test_backpressure();
        test_reset_mid_shift();
`ifdef ALU_SEQ_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 in_valid  in  1  operation request valid.
REQ-004 in_ready  out  1  sequencer can accept a request; high only in IDLE.
REQ-005 in_op  in  4  operation code, alu_seq_pkg::op_e.
REQ-006 in_a  in  32  operand A.
REQ-007 in_b  in  32  operand B; for shifts, in_b[4:0] is the shift amount and in_b[31:5] is ignored.
REQ-008 alu_sel  out  5  ALU selector driven to the external ALU.
REQ-009 alu_data1  out  32  ALU operand 1.
REQ-010 alu_data2  out  32  ALU operand 2.
REQ-011 alu_result  in  32  combinational ALU result for the current alu_sel/alu_data1/alu_data2.
REQ-012 out_valid  out  1  out_result valid.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_result  out  32  final result.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, SHIFT and DONE.
REQ-017 In IDLE, in_valid=1 SHALL latch op, A and B (the accept edge is T0).
REQ-018 After acceptance, the FSM SHALL go to SHIFT for SLL/SRL/SRA with shamt greater than 0, and to EXEC otherwise.
REQ-019 EXEC SHALL last 1 cycle, capture alu_result into the accumulator and go to DONE; out_valid SHALL rise at T0+2.
REQ-020 EXEC operand mapping SHALL be:
- ADD: sel 0, data (A,B).
- SUB: sel 1, (A,B).
- AND: sel 2.
- OR: sel 3.
- XOR: sel 4.
- SLTU: sel 9, (A,B).
- SLT: sel 9, (A^32'h8000_0000, B^32'h8000_0000).
- Shift with shamt=0: sel 0, (A,0).
REQ-021 Op codes 10-15 are illegal; in EXEC they SHALL drive sel 5'd31, data (0,0), and the captured result SHALL be 0.
REQ-022 SHIFT SHALL hold a down-counter loaded with shamt and drive the shift sel (SLL 5, SRL 6, SRA 7) with data1=accumulator and data2=0.
REQ-023 In SHIFT, each cycle SHALL load alu_result into the accumulator and decrement the counter; on the cycle the counter reaches 1, the FSM SHALL go to DONE, so out_valid rises at T0+shamt+1.
REQ-024 In DONE, out_valid=1 and out_result=accumulator SHALL hold stable until out_ready=1; that handshake cycle SHALL return the FSM to IDLE.
REQ-025 There is no overlap: in_ready=0 during DONE even when out_ready=1; the next request can be accepted at the earliest 1 cycle after the output handshake.
REQ-026 In IDLE and DONE, alu_sel/alu_data1/alu_data2 SHALL be driven to 0.
REQ-027 out_result SHALL be 0 whenever out_valid=0.
REQ-028 in_op/in_a/in_b changes after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-029 rst_n=0 at any clock edge SHALL force IDLE and clear the accumulator, counter and latched operands.
REQ-030 While in reset, outputs SHALL be: in_ready=0, busy=0, out_valid=0, out_result=0, alu_* =0.
REQ-031 On the first edge with rst_n=1, in_ready SHALL be 1.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL discard the operation with no output handshake.

Configuration
REQ-033 With ALU_SEQ_FLUSH_EN defined, an input port flush (1 bit) SHALL exist.
REQ-034 flush=1 SHALL return the FSM from any state to IDLE on that edge, discarding the operation; out_valid SHALL be 0 the next cycle.
REQ-035 flush SHALL take priority over acceptance and over the output handshake in the same cycle.
REQ-036 Without ALU_SEQ_FLUSH_EN, the flush port SHALL be absent and an operation SHALL be aborted only by reset.

Structure
REQ-037 Package alu_seq_pkg SHALL hold:
- op_e: ADD=0, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU=9.
- state_e.
- Constants for the ALU selector codes 0-9 and 31.
- SIGN_BIAS=32'h8000_0000.
REQ-038 No sub-module SHALL be instantiated; the ALU is instantiated beside the sequencer in the parent and connected through the alu_* ports.

Verification
REQ-039 ADD A=32'h7FFF_FFFF, B=1 -> out_valid at T0+2, out_result=32'h8000_0000; alu_sel=0 during EXEC.
REQ-040 SRA A=32'h8000_0000, B=31 -> alu_sel=7 for 31 SHIFT cycles, out_valid at T0+32, result=32'hFFFF_FFFF; SLL A=32'h1234, B=32'h25 -> shamt 5, result=32'h0002_4680 at T0+6.
REQ-041 SLT A=32'hFFFF_FFFF, B=1 -> 1; SLTU with the same operands -> 0; SLL with B=0, A=32'h1234 -> 32'h1234 at T0+2; op 12 -> 0 at T0+2.
REQ-042 out_ready held low 5 cycles in DONE -> out_valid and out_result stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, new request accepted.
REQ-043 rst_n=0 for 1 cycle at shift iteration 10 of 31 (and flush=1 when ALU_SEQ_FLUSH_EN is defined) -> next cycle IDLE, out_valid=0, in_ready=1, no stale result delivered.
